// File: rtl/cpu_sequencer.sv
// Main control sequencer for the 8-bit-bus accumulator CPU.
// Each instruction takes an 8-cycle frame: a two-byte fetch, then the execute strobes.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3,
    S4 = 4'd4, S5 = 4'd5, S6 = 4'd6, S7 = 4'd7,
    SH = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_ANDD = 3'd3,
    OP_XORR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7
  } op_e;

  state_e state_q, state_d;
  logic   skip_q, skip_d;
  op_e    op;
  logic   is_acc_op;

  assign op        = op_e'(opcode);
  assign is_acc_op = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
  assign state_o   = state_q;

  // Strobes are a pure decode of the current state so the datapath sees them in
  // the same cycle; ena low forces S0 and kills every strobe except in SH.
  always_comb begin
    load_ir     = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    state_d     = state_q;
    skip_d      = skip_q;
    if (state_q == SH) begin
      halt = 1'b1;
    end else if (!ena) begin
      state_d = S0;
      skip_d  = 1'b0;
    end else begin
      unique case (state_q)
        S0: begin
          rd = 1'b1; load_ir = 1'b1; inc_pc = 1'b1;
          state_d = S1;
        end
        S1: begin
          rd = 1'b1; load_ir = 1'b1; inc_pc = 1'b1;
          state_d = S2;
        end
        S2: state_d = S3;
        S3: begin
          if (op == OP_HLT) begin
            halt    = 1'b1;
            state_d = SH;
          end else begin
            state_d = S4;
          end
        end
        S4: begin
          if (op == OP_JMP) load_pc = 1'b1;
          if (is_acc_op) rd = 1'b1;
          if (op == OP_STO) datactl_ena = 1'b1;
          if (op == OP_SKZ) skip_d = zero;
          state_d = S5;
        end
        S5: begin
          if (is_acc_op) begin
            rd = 1'b1; load_acc = 1'b1;
          end
          if (op == OP_STO) begin
            datactl_ena = 1'b1; wr = 1'b1;
          end
          if (op == OP_SKZ && skip_q) inc_pc = 1'b1;
          state_d = S6;
        end
        S6: begin
          if (op == OP_STO) datactl_ena = 1'b1;
          if (op == OP_SKZ && skip_q) inc_pc = 1'b1;
          state_d = S7;
        end
        S7: begin
          skip_d  = 1'b0;
          state_d = S0;
        end
        default: begin
          skip_d  = 1'b0;
          state_d = S0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle scoreboard of all outputs
// plus per-frame strobe counts for each instruction class.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, ena, zero;
  logic [2:0] opcode;
  logic       load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;
  logic [3:0] state_o;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(load_ir), .rd(rd), .wr(wr), .inc_pc(inc_pc), .load_pc(load_pc),
    .load_acc(load_acc), .datactl_ena(datactl_ena), .halt(halt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3,
                         XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [11:0] sb[$];
  logic [3:0]  m_st = 4'd0;
  logic        m_sk = 1'b0;
  int n_ir, n_rd, n_wr, n_inc, n_pc, n_acc, n_dc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output vector: {state, load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt}
  function automatic logic [11:0] model_out(input logic [3:0] st, input logic sk,
                                            input logic en, input logic [2:0] op);
    logic [7:0] s;
    logic       acc_op;
    s = 8'b0;
    acc_op = (op >= ADD) && (op <= LDA);
    if (st == 4'd8)         s = 8'b0000_0001;
    else if (en) begin
      if (st <= 4'd1)       s = 8'b1101_0000;
      else if (st == 4'd3 && op == HLT) s = 8'b0000_0001;
      else if (st == 4'd4) begin
        if (op == JMP)      s = 8'b0000_1000;
        else if (acc_op)    s = 8'b0100_0000;
        else if (op == STO) s = 8'b0000_0010;
      end else if (st == 4'd5) begin
        if (acc_op)         s = 8'b0100_0100;
        else if (op == STO) s = 8'b0010_0010;
        else if (op == SKZ && sk) s = 8'b0001_0000;
      end else if (st == 4'd6) begin
        if (op == STO)      s = 8'b0000_0010;
        else if (op == SKZ && sk) s = 8'b0001_0000;
      end
    end
    return {st, s};
  endfunction

  task automatic step(input logic r, input logic e, input logic [2:0] op,
                      input logic z, input bit chk);
    logic [11:0] exp;
    rst = r; ena = e; opcode = op; zero = z;
    if (chk) sb.push_back(model_out(m_st, m_sk, e, op));
    #4;
    if (chk) begin
      exp = sb.pop_front();
      check("outs", {state_o, load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt}, exp);
      if (rd && wr) check("inv_rd_wr", 1, 0);
      if (wr && !datactl_ena) check("inv_wr_dc", 1, 0);
      if (load_ir && state_o > 4'd1) check("inv_ir", 1, 0);
      if (load_pc && inc_pc) check("inv_pc", 1, 0);
    end
    n_ir += load_ir; n_rd += rd; n_wr += wr; n_inc += inc_pc;
    n_pc += load_pc; n_acc += load_acc; n_dc += datactl_ena;
    @(posedge clk);
    if (r) begin
      m_st = 4'd0; m_sk = 1'b0;
    end else if (m_st != 4'd8) begin
      if (!e) begin
        m_st = 4'd0; m_sk = 1'b0;
      end else if (m_st == 4'd3 && op == HLT) m_st = 4'd8;
      else if (m_st == 4'd7) begin
        m_st = 4'd0; m_sk = 1'b0;
      end else begin
        if (m_st == 4'd4 && op == SKZ) m_sk = z;
        m_st = m_st + 4'd1;
      end
    end
    #1;
  endtask

  task automatic clr_counts();
    n_ir = 0; n_rd = 0; n_wr = 0; n_inc = 0; n_pc = 0; n_acc = 0; n_dc = 0;
  endtask

  // One 8-cycle frame from S0; zero is z4 in S4 and inverted elsewhere.
  task automatic run_frame(input logic [2:0] op, input logic z4);
    clr_counts();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, op, (i == 4) ? z4 : ~z4, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    clr_counts();
    step(1'b1, 1'b0, LDA, 1'b0, 1'b0);
    step(1'b1, 1'b0, LDA, 1'b0, 1'b1);
    check("rst_state", state_o, 0);
    step(1'b1, 1'b1, LDA, 1'b0, 1'b1);

    run_frame(LDA, 1'b0);
    check("lda_rd", n_rd, 4);   check("lda_ir", n_ir, 2);
    check("lda_acc", n_acc, 1); check("lda_inc", n_inc, 2);
    check("lda_wrap", state_o, 0);

    run_frame(STO, 1'b0);
    check("sto_dc", n_dc, 3);   check("sto_wr", n_wr, 1);
    check("sto_acc", n_acc, 0); check("sto_rd", n_rd, 2);

    run_frame(SKZ, 1'b1);
    check("skz1_inc", n_inc, 4);
    run_frame(SKZ, 1'b0);
    check("skz0_inc", n_inc, 2);

    run_frame(JMP, 1'b0);
    check("jmp_pc", n_pc, 1);   check("jmp_inc", n_inc, 2);

    run_frame(ADD, 1'b1);  check("add_acc", n_acc, 1);
    run_frame(ANDD, 1'b0); check("andd_rd", n_rd, 4);
    run_frame(XORR, 1'b1); check("xorr_acc", n_acc, 1);

    // ena drop while in S1 aborts the fetch
    step(1'b0, 1'b1, LDA, 1'b0, 1'b1);
    step(1'b0, 1'b0, LDA, 1'b0, 1'b1);
    check("abort_s0", state_o, 0);
    run_frame(LDA, 1'b0);
    check("restart_ir", n_ir, 2);

    // reset in S5 of a skipping SKZ
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, SKZ, 1'b1, 1'b1);
    step(1'b1, 1'b1, SKZ, 1'b1, 1'b1);
    check("rst_s5", state_o, 0);
    run_frame(SKZ, 1'b0);
    check("post_rst_inc", n_inc, 2);

    // HLT: sticky until reset
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, HLT, 1'b0, 1'b1);
    check("hlt_state", state_o, 8);
    clr_counts();
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    check("hlt_sticky", state_o, 8);
    check("hlt_strobes", n_rd + n_wr + n_inc + n_pc + n_acc + n_dc + n_ir, 0);
    step(1'b1, 1'b0, HLT, 1'b0, 1'b1);
    step(1'b0, 1'b0, LDA, 1'b0, 1'b1);
    check("hlt_exit", {state_o, halt}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Main control state machine of the 8-bit-bus accumulator CPU. It sequences each instruction through an 8-cycle frame. The frame fetches the 16-bit instruction over two bus reads into the instruction register, then generates the execute-phase strobes for memory, PC, accumulator and the data-bus driver. It sits between the clock/enable generator and the datapath, and consumes the opcode field (opc_iraddr[15:13]) and the ALU zero flag.

Parameters:
none; opcode encoding fixed: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  run enable from clock generator; low aborts/holds the sequencer at fetch start
opcode  input  3  instruction opcode from instruction register bits [15:13]
zero  input  1  accumulator-zero flag
load_ir  output  1  instruction register load enable; must be high for exactly two consecutive cycles per fetch
rd  output  1  memory read strobe
wr  output  1  memory write strobe
inc_pc  output  1  program counter increment
load_pc  output  1  program counter parallel load (jump target = IR[12:0])
load_acc  output  1  accumulator load
datactl_ena  output  1  enable accumulator onto data bus
halt  output  1  processor halted indicator
state_o  output  4  current state, debug/verification visibility

Behaviour:
- States: S0 FETCH_HI, S1 FETCH_LO, S2 DECODE, S3 EXEC1, S4 EXEC2, S5 EXEC3, S6 EXEC4, S7 NEXT, SH HALTED. Encoding is 0..7 for S0..S7 and 8 for SH.
- Outputs are a combinational decode of state, opcode and skip_q. Every strobe not listed below is 0.
- S0: rd=1, load_ir=1, inc_pc=1.
- S1: rd=1, load_ir=1, inc_pc=1. The opcode is valid from S1 onward and stable through S7.
- S2: no strobes.
- S3: HLT -> halt=1, next state SH. Any other opcode -> no strobes, next state S4.
- S4:
  - JMP -> load_pc=1.
  - ADD/ANDD/XORR/LDA -> rd=1.
  - STO -> datactl_ena=1.
  - SKZ -> no strobes; skip_q <= zero, sampled at the S4 edge.
- S5:
  - ADD/ANDD/XORR/LDA -> rd=1, load_acc=1.
  - STO -> datactl_ena=1, wr=1.
  - SKZ with skip_q=1 -> inc_pc=1.
- S6:
  - STO -> datactl_ena=1.
  - SKZ with skip_q=1 -> inc_pc=1.
  - The two increments in S5/S6 skip the next 2-byte instruction.
- S7: no strobes; skip_q cleared.
- Transitions: Sn -> Sn+1 for n=0..6 and S7 -> S0, each only when ena=1 (except the HLT exit from S3).
- Frame length: 8 cycles per non-HLT instruction.
- ena=0 in any state other than SH: next state S0, skip_q cleared, and all strobes forced 0 in that cycle. An aborted fetch therefore always restarts at the high byte, and load_ir drops so the IR byte pointer resets.
- SH is sticky:
  - halt=1 continuously; all other strobes 0.
  - ena is ignored.
  - Only rst exits SH.
- rst: state S0, skip_q=0. Outputs after reset:
  - With ena=0: all outputs 0, state_o=0.
  - With ena=1: the S0 decode applies (rd=1, load_ir=1, inc_pc=1).
- rst has priority over ena and over halt.
- Invariants:
  - rd and wr are never both 1.
  - wr=1 implies datactl_ena=1.
  - load_ir is never high outside S0/S1.
  - load_pc and inc_pc are never both 1.

Test Plan:
- rst=1 for 2 cycles, then ena=1, opcode=LDA (101) -> state_o sequence 0,1,…,7,0. rd high in S0, S1, S4 and S5; load_ir high in S0 and S1 only; load_acc=1 only in S5; inc_pc pulses exactly 2.
- opcode=STO (110) -> datactl_ena=1 in S4, S5 and S6; wr=1 only in S5; rd=0 in S2–S7; load_acc never asserted.
- opcode=SKZ (001) with zero=1 at S4 -> inc_pc=1 in S5 and S6 (4 PC increments in the frame). Repeat with zero=0 at S4 and zero=1 in S5 -> no increments after S1 (sampled skip_q governs).
- opcode=JMP (111) -> load_pc=1 only in S4, inc_pc=0 in S2–S7.
- opcode=HLT (000) -> halt=1 from S3, state_o=8 for 20 further cycles regardless of ena toggling, all other strobes 0; rst=1 -> state_o=0, halt=0.
- Drop ena for 1 cycle while in S1 -> next state_o=0 with load_ir=0 that cycle. Restore ena -> a clean fetch restarts at S0. Assert rst while in S5 -> state_o=0, skip_q=0 next cycle.
